// File: rtl/vga_txt_buf_ctrl.sv
// ---------------------------------------------------------------------------
// vga_txt_buf_ctrl
//
// Text-mode video buffer holding a COLS x ROWS character array in a
// dual-port RAM, with a write controller on the CPU side. Characters are
// written at a hardware cursor that auto-advances and wraps. Clear-screen and
// scroll are done by a fill engine. Scrolling moves a ring-buffer row offset
// (top_row) and blanks a single line, so no rows are copied. The video side
// reads cells by screen (column, row).
//
// Optional feature macro: VGA_TXT_BUF_CTRL_CHARS_EN
//   When defined, CR (8'h0D), LF (8'h0A) and BS (8'h08) move the cursor
//   instead of being stored. When undefined, every code is stored as a glyph.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_h      asynchronous reset, active high
//   i_d_we       character written at the cursor
//   i_wr_h       write strobe, one character per cycle
//   i_cur_set_h  load cursor from i_cur_col / i_cur_row (clamped)
//   i_cur_col    new cursor column
//   i_cur_row    new cursor row
//   i_clr_h      clear screen command
//   i_scroll_h   scroll up one line command
//   o_busy_h     fill engine running; CPU-side inputs are ignored
//   o_cur_col    current cursor column
//   o_cur_row    current cursor row
//   i_re_en_h    video read enable
//   i_vcol       video read column (screen coordinates)
//   i_vrow       video read row (screen coordinates)
//   o_d_re       video read data, valid two cycles after i_re_en_h
// ---------------------------------------------------------------------------
module vga_txt_buf_ctrl #(
    parameter int                COLS   = 80,
    parameter int                ROWS   = 30,
    parameter int                DATA_W = 8,
    parameter int                COL_W  = 7,
    parameter int                ROW_W  = 5,
    parameter int                ADDR_W = 12,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(8'h20)
) (
    input  logic              i_clk,
    input  logic              i_rst_h,
    input  logic [DATA_W-1:0] i_d_we,
    input  logic              i_wr_h,
    input  logic              i_cur_set_h,
    input  logic [COL_W-1:0]  i_cur_col,
    input  logic [ROW_W-1:0]  i_cur_row,
    input  logic              i_clr_h,
    input  logic              i_scroll_h,
    output logic              o_busy_h,
    output logic [COL_W-1:0]  o_cur_col,
    output logic [ROW_W-1:0]  o_cur_row,
    input  logic              i_re_en_h,
    input  logic [COL_W-1:0]  i_vcol,
    input  logic [ROW_W-1:0]  i_vrow,
    output logic [DATA_W-1:0] o_d_re
);

    typedef enum logic [1:0] {IDLE, CLR_SCR, CLR_LINE} state_t;

    localparam int                CELLS     = COLS * ROWS;
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    // Logical (screen) row to RAM address through the ring offset.
    // The sum is below 2*ROWS, so one conditional subtract replaces a modulo.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] lrow,
                                                    input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        logic [ROW_W:0] prow;
        sum  = {1'b0, lrow} + {1'b0, top};
        prow = (sum >= (ROW_W+1)'(ROWS)) ? sum - (ROW_W+1)'(ROWS) : sum;
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    state_t              state, state_nxt;
    logic [COL_W-1:0]    cur_col;
    logic [ROW_W-1:0]    cur_row;
    logic [ROW_W-1:0]    top_row;
    logic [ADDR_W-1:0]   eng_addr;
    logic [COL_W-1:0]    eng_col;

    logic                do_clr, do_scroll, do_set, do_wr, start_line;
    logic [COL_W-1:0]    wr_col_nxt;
    logic [ROW_W-1:0]    wr_row_nxt;
    logic                wr_scroll, wr_store;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [CELLS];

    logic                rd_v, rd_oob;
    logic [ADDR_W-1:0]   rd_addr;
    logic                vid_oob;

    // Command decode in IDLE: clear > scroll > cursor set > write.
    assign do_clr     = (state == IDLE) & i_clr_h;
    assign do_scroll  = (state == IDLE) & ~i_clr_h & i_scroll_h;
    assign do_set     = (state == IDLE) & ~i_clr_h & ~i_scroll_h & i_cur_set_h;
    assign do_wr      = (state == IDLE) & ~i_clr_h & ~i_scroll_h & ~i_cur_set_h & i_wr_h;
    assign start_line = do_scroll | (do_wr & wr_scroll);

    assign o_cur_col = cur_col;
    assign o_cur_row = cur_row;

    // Cursor movement for a write in IDLE.
    always_comb begin
        logic [COL_W-1:0] adv_col;
        logic [ROW_W-1:0] adv_row;
        logic             adv_scroll;
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        adv_col    = cur_col + 1'b1;
        adv_row    = cur_row;
        adv_scroll = 1'b0;
        if (cur_col == COL_MAX) begin
            adv_col = '0;
            if (cur_row == ROW_MAX) adv_scroll = 1'b1;
            else                    adv_row    = cur_row + 1'b1;
        end
        wr_col_nxt = adv_col;
        wr_row_nxt = adv_row;
        wr_scroll  = adv_scroll;
        wr_store   = 1'b1;
`ifdef VGA_TXT_BUF_CTRL_CHARS_EN
        case (i_d_we[7:0])
            8'h0D: begin
                wr_store   = 1'b0;
                wr_col_nxt = '0;
                wr_row_nxt = cur_row;
                wr_scroll  = 1'b0;
            end
            8'h0A: begin
                wr_store   = 1'b0;
                wr_col_nxt = cur_col;
                wr_row_nxt = (cur_row == ROW_MAX) ? cur_row : cur_row + 1'b1;
                wr_scroll  = (cur_row == ROW_MAX);
            end
            8'h08: begin
                wr_store   = 1'b0;
                wr_col_nxt = (cur_col == '0) ? cur_col : cur_col - 1'b1;
                wr_row_nxt = cur_row;
                wr_scroll  = 1'b0;
            end
            default: ;
        endcase
`endif
    end

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst_h) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (i_rst_h) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (do_clr)          state_nxt = CLR_SCR;
                else if (start_line) state_nxt = CLR_LINE;
            end
            CLR_SCR:  if (eng_addr == LAST_ADDR) state_nxt = IDLE;
            CLR_LINE: if (eng_col == COL_MAX)    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM: outputs and RAM write port. Engine and CPU writes are exclusive by state.
    always_comb begin
        o_busy_h  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cell_addr(cur_row, cur_col, top_row);
        mem_wdata = i_d_we;
        unique case (state)
            IDLE: mem_we = do_wr & wr_store;
            CLR_SCR, CLR_LINE: begin
                o_busy_h  = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = eng_addr;
                mem_wdata = FILL;
            end
            default: ;
        endcase
    end

    // Cursor, ring offset and fill engine counters.
    always_ff @(posedge i_clk or posedge i_rst_h) begin
        if (i_rst_h) begin
            cur_col  <= '0;
            cur_row  <= '0;
            top_row  <= '0;
            eng_addr <= '0;
            eng_col  <= '0;
        end else if (state == IDLE) begin
            if (do_clr) begin
                cur_col  <= '0;
                cur_row  <= '0;
                top_row  <= '0;
                eng_addr <= '0;
            end else begin
                if (start_line) begin
                    // The old top physical row becomes the new bottom line.
                    eng_addr <= cell_addr('0, '0, top_row);
                    eng_col  <= '0;
                    top_row  <= (top_row == ROW_MAX) ? '0 : top_row + 1'b1;
                end
                if (do_set) begin
                    cur_col <= (i_cur_col > COL_MAX) ? COL_MAX : i_cur_col;
                    cur_row <= (i_cur_row > ROW_MAX) ? ROW_MAX : i_cur_row;
                end
                if (do_wr) begin
                    cur_col <= wr_col_nxt;
                    cur_row <= wr_row_nxt;
                end
            end
        end else begin
            eng_addr <= eng_addr + 1'b1;
            eng_col  <= eng_col + 1'b1;
        end
    end

    // NOTE: the character RAM has no reset so it maps onto block RAM;
    // its contents are only defined after a clear.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Video read: address stage, then RAM read into the output register.
    assign vid_oob = (i_vcol > COL_MAX) | (i_vrow > ROW_MAX);

    always_ff @(posedge i_clk or posedge i_rst_h) begin
        if (i_rst_h) begin
            rd_v    <= 1'b0;
            rd_oob  <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_v <= i_re_en_h;
            if (i_re_en_h) begin
                rd_oob  <= vid_oob;
                rd_addr <= vid_oob ? '0 : cell_addr(i_vrow, i_vcol, top_row);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_h) begin
        if (i_rst_h)   o_d_re <= '0;
        else if (rd_v) o_d_re <= rd_oob ? FILL : mem[rd_addr];
    end

endmodule

// File: tb/tb_vga_txt_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_txt_buf_ctrl
//
// Directed bench for vga_txt_buf_ctrl with default parameters. Expected screen
// contents come from a behavioural screen model (a plain 2-D array that
// shifts rows on scroll). Video reads push their expected value into a queue
// when issued and are popped and compared when the data is due two cycles
// later. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vga_txt_buf_ctrl;

    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int WAIT_LIMIT = 5000;
    localparam logic [7:0] SP = 8'h20;

    typedef struct {
        logic [7:0] exp;
        int         col;
        int         row;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_we;
    logic       wr, cur_set, clr, scroll, re_en;
    logic [6:0] cur_col_in, vcol;
    logic [4:0] cur_row_in, vrow;
    logic       busy;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic [7:0] d_re;

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         cyc;
    logic [7:0] model [ROWS][COLS];
    rd_t        rq[$];

    vga_txt_buf_ctrl dut (
        .i_clk       (clk),
        .i_rst_h     (rst),
        .i_d_we      (d_we),
        .i_wr_h      (wr),
        .i_cur_set_h (cur_set),
        .i_cur_col   (cur_col_in),
        .i_cur_row   (cur_row_in),
        .i_clr_h     (clr),
        .i_scroll_h  (scroll),
        .o_busy_h    (busy),
        .o_cur_col   (cur_col),
        .o_cur_row   (cur_row),
        .i_re_en_h   (re_en),
        .i_vcol      (vcol),
        .i_vrow      (vrow),
        .o_d_re      (d_re)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cur_col), 32'(col));
        check({tag, "_row"}, 32'(cur_row), 32'(row));
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = SP;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < ROWS - 1; r++) model[r] = model[r + 1];
        for (int c = 0; c < COLS; c++) model[ROWS-1][c] = SP;
    endtask

    // One CPU-side cycle; called and returns on a falling edge.
    task automatic cpu_cycle(input logic c_clr, input logic c_scroll, input logic c_set,
                             input int col, input int row, input logic c_wr, input logic [7:0] d);
        clr = c_clr; scroll = c_scroll; cur_set = c_set;
        cur_col_in = 7'(col); cur_row_in = 5'(row);
        wr = c_wr; d_we = d;
        @(negedge clk);
        clr = 1'b0; scroll = 1'b0; cur_set = 1'b0; wr = 1'b0;
    endtask

    // Counts busy cycles until idle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < WAIT_LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic pop_check();
        rd_t e;
        e = rq.pop_front();
        check($sformatf("read(%0d,%0d)", e.col, e.row), 32'(d_re), 32'(e.exp));
    endtask

    task automatic read_one(input int col, input int row, input logic [7:0] exp);
        rq.push_back('{exp, col, row});
        re_en = 1'b1; vcol = 7'(col); vrow = 5'(row);
        @(negedge clk);
        re_en = 1'b0;
        @(negedge clk);
        pop_check();
    endtask

    // Back-to-back reads over the whole screen against the model.
    task automatic scan_all();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rq.size() == 2) pop_check();
                re_en = 1'b1; vcol = 7'(c); vrow = 5'(r);
                rq.push_back('{model[r][c], c, r});
                @(negedge clk);
            end
        end
        re_en = 1'b0;
        pop_check();
        @(negedge clk);
        pop_check();
    endtask

    initial begin
        rst = 1'b1; d_we = '0; wr = 0; cur_set = 0; clr = 0; scroll = 0; re_en = 0;
        cur_col_in = '0; cur_row_in = '0; vcol = '0; vrow = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check_cursor("rst_cursor", 0, 0);
        check("rst_d_re", 32'(d_re), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Out-of-range video reads return FILL
        read_one(90, 0, SP);
        read_one(0, 30, SP);

        // Clear screen: busy for exactly COLS*ROWS cycles
        cpu_cycle(1, 0, 0, 0, 0, 0, 8'h00);
        check("clr_busy_start", 32'(busy), 32'd1);
        wait_idle(cyc);
        check("clr_busy_cycles", 32'(cyc), 32'd2400);
        check_cursor("clr_cursor", 0, 0);
        model_clear();
        scan_all();

        // Cursor set and write
        cpu_cycle(0, 0, 1, 5, 3, 0, 8'h00);
        check_cursor("set_cursor", 5, 3);
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h41);
        model[3][5] = 8'h41;
        check_cursor("wr_cursor", 6, 3);
        read_one(5, 3, 8'h41);
        repeat (3) @(negedge clk);
        check("read_hold", 32'(d_re), 32'h41);

        // Cursor clamp
        cpu_cycle(0, 0, 1, 100, 31, 0, 8'h00);
        check_cursor("clamp_cursor", 79, 29);

        // Write at the last cell triggers an auto-scroll
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h42);
        model[29][79] = 8'h42;
        check("autoscroll_busy_start", 32'(busy), 32'd1);
        wait_idle(cyc);
        check("autoscroll_busy_cycles", 32'(cyc), 32'd80);
        model_scroll();
        check_cursor("autoscroll_cursor", 0, 29);
        read_one(79, 28, 8'h42);
        read_one(5, 2, 8'h41);
        scan_all();

        // Scroll beats cursor set; inputs during busy are ignored
        cpu_cycle(0, 1, 1, 3, 3, 0, 8'h00);
        model_scroll();
        check("scroll_busy_start", 32'(busy), 32'd1);
        wr = 1'b1; d_we = 8'h51; cur_set = 1'b1; cur_col_in = 7'd2; cur_row_in = 5'd2;
        repeat (10) @(negedge clk);
        wr = 1'b0; cur_set = 1'b0;
        wait_idle(cyc);
        check_cursor("scroll_busy_cursor", 0, 29);

        // Thirty-plus scrolls with a marker per line: ring offset wraps
        for (int i = 0; i < 30; i++) begin
            cpu_cycle(0, 0, 1, 0, 29, 0, 8'h00);
            cpu_cycle(0, 0, 0, 0, 0, 1, 8'(8'h30 + i));
            model[29][0] = 8'(8'h30 + i);
            cpu_cycle(0, 1, 0, 0, 0, 0, 8'h00);
            model_scroll();
            wait_idle(cyc);
        end
        check_cursor("scroll_loop_cursor", 1, 29);
        scan_all();

        // Clear and write in the same cycle: clear wins; writes during busy dropped
        cpu_cycle(0, 0, 1, 10, 10, 0, 8'h00);
        cpu_cycle(1, 0, 0, 0, 0, 1, 8'h58);
        model_clear();
        check("clrwr_busy", 32'(busy), 32'd1);
        check_cursor("clrwr_cursor", 0, 0);
        wr = 1'b1; d_we = 8'h59;
        repeat (20) @(negedge clk);
        wr = 1'b0;
        wait_idle(cyc);
        check_cursor("clrwr_after_cursor", 0, 0);
        read_one(0, 0, SP);
        read_one(10, 10, SP);

        // Control codes
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h41);
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h0D);
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h0A);
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h42);
`ifdef VGA_TXT_BUF_CTRL_CHARS_EN
        model[0][0] = 8'h41;
        model[1][0] = 8'h42;
        check_cursor("ctrl_cursor", 1, 1);
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h08);
        check_cursor("bs_cursor", 0, 1);
        cpu_cycle(0, 0, 0, 0, 0, 1, 8'h08);
        check_cursor("bs_stop_cursor", 0, 1);
`else
        model[0][0] = 8'h41;
        model[0][1] = 8'h0D;
        model[0][2] = 8'h0A;
        model[0][3] = 8'h42;
        check_cursor("ctrl_cursor", 4, 0);
`endif
        for (int c = 0; c < 4; c++) read_one(c, 0, model[0][c]);
        read_one(0, 1, model[1][0]);

        // Reset in the middle of a clear
        cpu_cycle(1, 0, 0, 0, 0, 0, 8'h00);
        repeat (999) @(negedge clk);
        check("midclr_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midclr_rst_busy", 32'(busy), 32'd0);
        check_cursor("midclr_rst_cursor", 0, 0);
        check("midclr_rst_d_re", 32'(d_re), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midclr_busy_after", 32'(busy), 32'd0);
        read_one(90, 5, SP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
